// File: rtl/eprisc_rom_arb_pkg.sv
// Shared types and constants for the boot-ROM arbiter: FSM states, requester IDs and
// default geometry of the 256x32 ROM.
package eprisc_rom_arb_pkg;

  localparam int unsigned AddrWDefault = 8;
  localparam int unsigned DataWDefault = 32;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_BUS   = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StDone
  } state_e;

endpackage

// File: rtl/eprisc_rom_arb_pick.sv
// Combinational 2-way picker between the fetch and bus requesters.
// EPRISC_ROM_ARB_RR_EN selects round-robin on ties; otherwise fetch has fixed priority.
module eprisc_rom_arb_pick
  import eprisc_rom_arb_pkg::*;
(
  input  logic iFetchReq,
  input  logic iBusReq,
  input  logic iLastGrant,
  output logic oWinner,
  output logic oValid
);

`ifdef EPRISC_ROM_ARB_RR_EN
  always_comb begin
    oValid  = iFetchReq | iBusReq;
    oWinner = GNT_FETCH;
    if (iFetchReq && iBusReq) begin
      // Tie goes to whichever port did not win last time.
      oWinner = ~iLastGrant;
    end else if (iBusReq) begin
      oWinner = GNT_BUS;
    end
  end
`else
  logic unusedLastGrant;
  assign unusedLastGrant = iLastGrant;

  always_comb begin
    oValid  = iFetchReq | iBusReq;
    oWinner = GNT_FETCH;
    if (!iFetchReq && iBusReq) begin
      oWinner = GNT_BUS;
    end
  end
`endif

endmodule

// File: rtl/eprisc_rom_arbiter.sv
// Shares the boot ROM's single synchronous-read port between instruction fetch and the
// system bus. Define EPRISC_ROM_ARB_RR_EN for round-robin arbitration on simultaneous requests.
module eprisc_rom_arbiter
  import eprisc_rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iFetchReq,
  input  logic [ADDR_W-1:0] iFetchAddr,
  output logic              oFetchAck,
  output logic [DATA_W-1:0] oFetchData,
  input  logic              iBusReq,
  input  logic [ADDR_W-1:0] iBusAddr,
  output logic              oBusAck,
  output logic [DATA_W-1:0] oBusData,
  output logic [ADDR_W-1:0] oRomAddr,
  output logic              oRomEnable,
  input  logic [DATA_W-1:0] iRomData,
  output logic              oBusy
);

  state_e            stateQ, stateD;
  logic              grantQ, grantD;
  logic [ADDR_W-1:0] romAddrQ, romAddrD;
  logic              romEnQ, romEnD;
  logic              fetchAckQ, fetchAckD;
  logic              busAckQ, busAckD;
  logic [DATA_W-1:0] fetchDataQ, fetchDataD;
  logic [DATA_W-1:0] busDataQ, busDataD;

  logic lastGrant;
  logic pickWinner;
  logic pickValid;

`ifdef EPRISC_ROM_ARB_RR_EN
  logic lastGrantQ, lastGrantD;
  assign lastGrant = lastGrantQ;
`else
  assign lastGrant = GNT_BUS;
`endif

  eprisc_rom_arb_pick uPick (
    .iFetchReq (iFetchReq),
    .iBusReq   (iBusReq),
    .iLastGrant(lastGrant),
    .oWinner   (pickWinner),
    .oValid    (pickValid)
  );

  always_comb begin
    stateD     = stateQ;
    grantD     = grantQ;
    romAddrD   = romAddrQ;
    romEnD     = romEnQ;
    fetchAckD  = 1'b0;
    busAckD    = 1'b0;
    fetchDataD = fetchDataQ;
    busDataD   = busDataQ;
`ifdef EPRISC_ROM_ARB_RR_EN
    lastGrantD = lastGrantQ;
`endif
    unique case (stateQ)
      StIdle: begin
        if (pickValid) begin
          grantD   = pickWinner;
          romAddrD = (pickWinner == GNT_BUS) ? iBusAddr : iFetchAddr;
          romEnD   = 1'b1;
          stateD   = StAddr;
`ifdef EPRISC_ROM_ARB_RR_EN
          lastGrantD = pickWinner;
`endif
        end
      end
      // ROM samples oRomAddr at the end of this cycle.
      StAddr: stateD = StData;
      StData: begin
        if (grantQ == GNT_BUS) begin
          busDataD = iRomData;
          busAckD  = 1'b1;
        end else begin
          fetchDataD = iRomData;
          fetchAckD  = 1'b1;
        end
        romEnD = 1'b0;
        stateD = StDone;
      end
      StDone: stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      stateQ     <= StIdle;
      grantQ     <= GNT_FETCH;
      romAddrQ   <= '0;
      romEnQ     <= 1'b0;
      fetchAckQ  <= 1'b0;
      busAckQ    <= 1'b0;
      fetchDataQ <= '0;
      busDataQ   <= '0;
`ifdef EPRISC_ROM_ARB_RR_EN
      lastGrantQ <= GNT_BUS;
`endif
    end else begin
      stateQ     <= stateD;
      grantQ     <= grantD;
      romAddrQ   <= romAddrD;
      romEnQ     <= romEnD;
      fetchAckQ  <= fetchAckD;
      busAckQ    <= busAckD;
      fetchDataQ <= fetchDataD;
      busDataQ   <= busDataD;
`ifdef EPRISC_ROM_ARB_RR_EN
      lastGrantQ <= lastGrantD;
`endif
    end
  end

  assign oFetchAck  = fetchAckQ;
  assign oFetchData = fetchDataQ;
  assign oBusAck    = busAckQ;
  assign oBusData   = busDataQ;
  assign oRomAddr   = romAddrQ;
  assign oRomEnable = romEnQ;
  assign oBusy      = (stateQ != StIdle);

  assert property (@(posedge iClk) disable iff (iReset) !(fetchAckQ && busAckQ));
  assert property (@(posedge iClk) disable iff (iReset)
                   romEnQ == ((stateQ == StAddr) || (stateQ == StData)));

endmodule
